// File: rtl/rvb_arb_pkg.sv
// Shared constants and the round-robin pick function for the rvb_arbiter slice.
// Optional statistics counters are enabled with RVB_ARB_STATS_EN (see rvb_arbiter.sv).
package rvb_arb_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_DEPTH = 4;

  localparam int TAG_W = $clog2(DEF_NREQ);
  localparam int CNT_W = $clog2(DEF_DEPTH) + 1;

  // The pick function is written for the largest supported requester count.
  localparam int MAX_NREQ = 8;
  localparam int PICK_W   = 3;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo nreq; returns ptr when none is set.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                input logic [PICK_W-1:0]   ptr,
                                                input int                  nreq);
    logic [PICK_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k < nreq) && valid[idx[PICK_W-1:0]]) begin
        pick  = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rvb_arbiter_if.sv
// Requester-side and worker-side buses of the rvb_arbiter, bundled in one interface.
// master = the arbiter's view; slave = the requesters and the worker around it.
interface rvb_arbiter_if
  import rvb_arb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREQ = DEF_NREQ
);

  // Every channel is valid/ready: a transfer happens on a clock edge where both are high;
  // the source holds payload stable while valid && !ready, and ready may depend on valid.
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_insn;
  logic [NREQ*XLEN-1:0] req_rs1;
  logic [NREQ*XLEN-1:0] req_rs2;
  logic [NREQ*XLEN-1:0] req_rs3;

  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [XLEN-1:0]      resp_rd;

  logic                 wk_din_valid;
  logic                 wk_din_ready;
  logic [31:0]          wk_din_insn;
  logic [XLEN-1:0]      wk_din_rs1;
  logic [XLEN-1:0]      wk_din_rs2;
  logic [XLEN-1:0]      wk_din_rs3;

  logic                 wk_dout_valid;
  logic                 wk_dout_ready;
  logic [XLEN-1:0]      wk_dout_rd;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, req_rs3,
    output req_ready,
    output resp_valid, resp_rd,
    input  resp_ready,
    output wk_din_valid, wk_din_insn, wk_din_rs1, wk_din_rs2, wk_din_rs3,
    input  wk_din_ready,
    input  wk_dout_valid, wk_dout_rd,
    output wk_dout_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, req_rs3,
    input  req_ready,
    input  resp_valid, resp_rd,
    output resp_ready,
    input  wk_din_valid, wk_din_insn, wk_din_rs1, wk_din_rs2, wk_din_rs3,
    output wk_din_ready,
    output wk_dout_valid, wk_dout_rd,
    input  wk_dout_ready
  );

endinterface

// File: rtl/rvb_arb_tagfifo.sv
// Synchronous FIFO of requester tags, one entry per op in flight in the worker.
// DEPTH must be a power of two so the pointers wrap naturally.
module rvb_arb_tagfifo
  import rvb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = TAG_W,
  parameter int CW    = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rvb_arbiter.sv
// Round-robin share of one in-order bitmanip worker among NREQ requesters; results are routed
// back through a tag FIFO. Define RVB_ARB_STATS_EN to add grant_cnt/stall_cnt counters.
module rvb_arbiter
  import rvb_arb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREQ  = DEF_NREQ,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  rvb_arbiter_if.master        bus,
  output logic                 err
`ifdef RVB_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int L_TAG_W = $clog2(NREQ);
  localparam int L_CNT_W = $clog2(DEPTH) + 1;

  logic [L_TAG_W-1:0]  r_rr_ptr;
  logic                r_err;
  logic [L_TAG_W-1:0]  w_grant;
  logic [L_TAG_W-1:0]  w_head;
  logic [MAX_NREQ-1:0] w_valid_ext;
  logic                w_any;
  logic                w_full;
  logic                w_empty;
  logic                w_issue_ok;
  logic                w_push;
  logic                w_pop;

  assign w_valid_ext = MAX_NREQ'(bus.req_valid);
  assign w_grant     = L_TAG_W'(rr_pick(w_valid_ext, PICK_W'(r_rr_ptr), NREQ));
  assign w_any       = |bus.req_valid;
  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign w_issue_ok  = w_any && !w_full && !reset;
  assign w_push      = w_issue_ok && bus.wk_din_ready;

  assign bus.wk_din_valid = w_issue_ok;
  assign bus.wk_din_insn  = bus.req_insn[32*w_grant +: 32];
  assign bus.wk_din_rs1   = bus.req_rs1[XLEN*w_grant +: XLEN];
  assign bus.wk_din_rs2   = bus.req_rs2[XLEN*w_grant +: XLEN];
  assign bus.wk_din_rs3   = bus.req_rs3[XLEN*w_grant +: XLEN];

  always_comb begin
    bus.req_ready = '0;
    if (w_push) bus.req_ready[w_grant] = 1'b1;
  end

  // Results go back to the requester recorded at the FIFO head, with no added latency.
  always_comb begin
    bus.resp_valid = '0;
    if (bus.wk_dout_valid && !w_empty) bus.resp_valid[w_head] = 1'b1;
  end

  assign bus.wk_dout_ready = !w_empty && bus.resp_ready[w_head];
  assign bus.resp_rd       = bus.wk_dout_rd;
  assign w_pop             = bus.wk_dout_valid && bus.wk_dout_ready;
  assign err               = r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_rr_ptr <= (int'(w_grant) == NREQ - 1) ? '0 : w_grant + L_TAG_W'(1);
      if (bus.wk_dout_valid && w_empty) r_err <= 1'b1;
    end
  end

  rvb_arb_tagfifo #(
    .DEPTH (DEPTH),
    .W     (L_TAG_W),
    .CW    (L_CNT_W)
  ) u_tagfifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_grant),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef RVB_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NREQ];
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall   = w_any && (w_full || !bus.wk_din_ready);
  assign stall_cnt = r_stall_cnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_out
    assign grant_cnt[16*gi +: 16] = r_grant_cnt[gi];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      for (int i = 0; i < NREQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      for (int i = 0; i < NREQ; i++) begin
        if (w_push && (w_grant == L_TAG_W'(i)) && (r_grant_cnt[i] != 16'hFFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvb_arbiter.sv
// Bench for rvb_arbiter: directed scenarios plus a randomized run against a queue-based model.
// The statistics scenario is compiled only when RVB_ARB_STATS_EN is defined.
module tb_rvb_arbiter;

  localparam int XLEN  = 32;
  localparam int NREQ  = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic err;
  int   checks;
  int   failures;

`ifdef RVB_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  rvb_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  rvb_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .err   (err)
`ifdef RVB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Worker behaviour used by the bench: any deterministic function of the forwarded op.
  function automatic logic [XLEN-1:0] wk_fn(input logic [31:0] insn, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
    return ((a ^ b) + c) ^ insn;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_insn      = '0;
    bus.req_rs1       = '0;
    bus.req_rs2       = '0;
    bus.req_rs3       = '0;
    bus.resp_ready    = '0;
    bus.wk_din_ready  = 1'b0;
    bus.wk_dout_valid = 1'b0;
    bus.wk_dout_rd    = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] insn, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
    bus.req_insn[32*i +: 32]  = insn;
    bus.req_rs1[XLEN*i +: XLEN] = a;
    bus.req_rs2[XLEN*i +: XLEN] = b;
    bus.req_rs3[XLEN*i +: XLEN] = c;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] insn0;
    insn0 = $urandom;
    rst = 1'b1;
    idle_inputs();
    bus.req_valid    = 2'b11;
    bus.wk_din_ready = 1'b1;
    bus.resp_ready   = 2'b11;
    set_req(0, insn0, $urandom, $urandom, $urandom);
    set_req(1, $urandom, $urandom, $urandom, $urandom);
    @(posedge clk); #4;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.wk_din_valid !== 1'b0) begin failures++; $display("FAIL reset_din_valid: got %b want 0", bus.wk_din_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ({bus.resp_valid, bus.wk_dout_ready} !== 3'b000) begin failures++; $display("FAIL reset_resp: got %b want 000", {bus.resp_valid, bus.wk_dout_ready}); end
    @(posedge clk); #1 rst = 1'b0;
    #3;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL first_grant: got %b want 01", bus.req_ready); end
    checks++; if (bus.wk_din_insn !== insn0) begin failures++; $display("FAIL first_grant_insn: got %h want %h", bus.wk_din_insn, insn0); end
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [31:0]     ins [NREQ];
    logic [XLEN-1:0] r1 [NREQ];
    logic [XLEN-1:0] r2 [NREQ];
    logic [XLEN-1:0] r3 [NREQ];
    logic [XLEN-1:0] exp_q[$];
    int              exp_g [4] = '{0, 1, 0, 1};
    int              g;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      ins[i] = $urandom; r1[i] = $urandom; r2[i] = $urandom; r3[i] = $urandom;
      set_req(i, ins[i], r1[i], r2[i], r3[i]);
    end
    bus.req_valid    = 2'b11;
    bus.wk_din_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      g = exp_g[c];
      checks++; if (bus.req_ready !== NREQ'(1 << g)) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, NREQ'(1 << g)); end
      checks++; if ({bus.wk_din_insn, bus.wk_din_rs1, bus.wk_din_rs2, bus.wk_din_rs3} !== {ins[g], r1[g], r2[g], r3[g]}) begin
        failures++; $display("FAIL rr_operands[%0d]: got %h want %h", c, {bus.wk_din_insn, bus.wk_din_rs1}, {ins[g], r1[g]});
      end
      exp_q.push_back(wk_fn(ins[g], r1[g], r2[g], r3[g]));
      @(posedge clk); #1;
      ins[g] = $urandom; r1[g] = $urandom; r2[g] = $urandom; r3[g] = $urandom;
      set_req(g, ins[g], r1[g], r2[g], r3[g]);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      bus.wk_dout_valid = 1'b1;
      bus.wk_dout_rd    = exp_q[c];
      #3;
      checks++; if (bus.resp_valid !== NREQ'(1 << exp_g[c])) begin failures++; $display("FAIL rr_resp_valid[%0d]: got %b want %b", c, bus.resp_valid, NREQ'(1 << exp_g[c])); end
      checks++; if (bus.resp_rd !== exp_q[c]) begin failures++; $display("FAIL rr_resp_rd[%0d]: got %h want %h", c, bus.resp_rd, exp_q[c]); end
      checks++; if (bus.wk_dout_ready !== 1'b1) begin failures++; $display("FAIL rr_dout_ready[%0d]: got %b want 1", c, bus.wk_dout_ready); end
      @(posedge clk); #1;
    end
    bus.wk_dout_valid = 1'b0;
    #3;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  task automatic test_full();
    int accepted;
    apply_reset();
    accepted = 0;
    bus.req_valid    = 2'b11;
    bus.wk_din_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (bus.req_ready != '0) accepted++;
      if (c >= 4) begin
        checks++; if ({bus.wk_din_valid, bus.req_ready} !== 3'b000) begin failures++; $display("FAIL full_blocks[%0d]: got %b want 000", c, {bus.wk_din_valid, bus.req_ready}); end
      end
      @(posedge clk); #1;
    end
    checks++; if (accepted !== 4) begin failures++; $display("FAIL full_accepted: got %0d want 4", accepted); end
    bus.wk_dout_valid = 1'b1;
    bus.wk_dout_rd    = $urandom;
    bus.resp_ready    = 2'b11;
    #3;
    checks++; if ({bus.wk_dout_ready, bus.wk_din_valid} !== 2'b10) begin failures++; $display("FAIL full_pop_cycle: got %b want 10", {bus.wk_dout_ready, bus.wk_din_valid}); end
    @(posedge clk); #1;
    bus.wk_dout_valid = 1'b0;
    #3;
    checks++; if ({bus.wk_din_valid, bus.req_ready} !== 3'b101) begin failures++; $display("FAIL full_reissue: got %b want 101", {bus.wk_din_valid, bus.req_ready}); end
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.req_valid    = 2'b10;
    bus.wk_din_ready = 1'b1;
    #3;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL bp_issue: got %b want 10", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid     = '0;
    bus.wk_dout_valid = 1'b1;
    bus.wk_dout_rd    = $urandom;
    bus.resp_ready    = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++; if ({bus.resp_valid, bus.wk_dout_ready} !== 3'b100) begin failures++; $display("FAIL bp_hold[%0d]: got %b want 100", c, {bus.resp_valid, bus.wk_dout_ready}); end
      @(posedge clk); #1;
    end
    bus.resp_ready = 2'b10;
    #3;
    checks++; if (bus.wk_dout_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got %b want 1", bus.wk_dout_ready); end
    @(posedge clk); #1;
    bus.wk_dout_valid = 1'b0;
    bus.req_valid     = 2'b01;
    @(posedge clk); #1;
    bus.req_valid     = '0;
    bus.wk_dout_valid = 1'b1;
    bus.resp_ready    = 2'b11;
    #3;
    checks++; if (bus.resp_valid !== 2'b01) begin failures++; $display("FAIL bp_next_head: got %b want 01", bus.resp_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bp_err: got %b want 0", err); end
    @(posedge clk); #1;
    bus.wk_dout_valid = 1'b0;
  endtask

  task automatic test_protocol_error();
    apply_reset();
    bus.wk_dout_valid = 1'b1;
    bus.resp_ready    = 2'b11;
    #3;
    checks++; if ({bus.wk_dout_ready, bus.resp_valid, err} !== 4'b0000) begin failures++; $display("FAIL perr_before: got %b want 0000", {bus.wk_dout_ready, bus.resp_valid, err}); end
    @(posedge clk); #1;
    bus.wk_dout_valid = 1'b0;
    #3;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL perr_set: got %b want 1", err); end
    repeat (3) @(posedge clk);
    #4;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL perr_sticky: got %b want 1", err); end
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL perr_cleared: got %b want 0", err); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

`ifdef RVB_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    bus.wk_din_ready = 1'b1;
    bus.req_valid    = 2'b01;
    repeat (3) @(posedge clk);
    #1 bus.req_valid = '0;
    bus.wk_dout_valid = 1'b1;
    bus.resp_ready    = 2'b11;
    repeat (3) @(posedge clk);
    #1 bus.wk_dout_valid = 1'b0;
    bus.req_valid = 2'b10;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = '0;
    #3;
    checks++; if (grant_cnt !== {16'd2, 16'd3}) begin failures++; $display("FAIL stats_grant: got %h want %h", grant_cnt, {16'd2, 16'd3}); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stats_stall0: got %0d want 0", stall_cnt); end
    bus.req_valid    = 2'b01;
    bus.wk_din_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = '0;
    #3;
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL stats_stall1: got %0d want 1", stall_cnt); end
  endtask
`endif

  // Randomized traffic; the model tracks in-flight tags and results as plain queues.
  task automatic test_random();
    logic [31:0]     ins [NREQ];
    logic [XLEN-1:0] r1 [NREQ];
    logic [XLEN-1:0] r2 [NREQ];
    logic [XLEN-1:0] r3 [NREQ];
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] e_rr;
    logic [NREQ-1:0] e_rv;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] wk_q[$];
    int              tag_q[$];
    int              next_ptr;
    int              g;
    int              h;
    logic            e_dv;
    logic            e_dr;
    apply_reset();
    vld = '0;
    acc = '0;
    next_ptr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!(vld[i] && !acc[i])) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          ins[i] = $urandom; r1[i] = $urandom; r2[i] = $urandom; r3[i] = $urandom;
        end
        set_req(i, ins[i], r1[i], r2[i], r3[i]);
      end
      bus.req_valid    = vld;
      bus.wk_din_ready = ($urandom_range(0, 3) != 0);
      bus.resp_ready   = NREQ'($urandom);
      if (wk_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.wk_dout_valid = 1'b1;
        bus.wk_dout_rd    = wk_q[0];
      end else begin
        bus.wk_dout_valid = 1'b0;
        bus.wk_dout_rd    = $urandom;
      end
      #3;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && vld[(next_ptr + k) % NREQ]) g = (next_ptr + k) % NREQ;
      end
      e_dv = (g >= 0) && (tag_q.size() < DEPTH);
      e_rr = (e_dv && bus.wk_din_ready) ? NREQ'(1 << g) : '0;
      h    = (tag_q.size() > 0) ? tag_q[0] : 0;
      e_rv = (tag_q.size() > 0 && bus.wk_dout_valid) ? NREQ'(1 << h) : '0;
      e_dr = (tag_q.size() > 0) && bus.resp_ready[h];
      checks++; if (bus.wk_din_valid !== e_dv) begin failures++; $display("FAIL rnd_din_valid[%0d]: got %b want %b", cyc, bus.wk_din_valid, e_dv); end
      checks++; if (bus.req_ready !== e_rr) begin failures++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", cyc, bus.req_ready, e_rr); end
      if (e_dv) begin
        checks++; if ({bus.wk_din_insn, bus.wk_din_rs1, bus.wk_din_rs2, bus.wk_din_rs3} !== {ins[g], r1[g], r2[g], r3[g]}) begin
          failures++; $display("FAIL rnd_operands[%0d]: got %h want %h", cyc, {bus.wk_din_insn, bus.wk_din_rs1}, {ins[g], r1[g]});
        end
      end
      checks++; if (bus.resp_valid !== e_rv) begin failures++; $display("FAIL rnd_resp_valid[%0d]: got %b want %b", cyc, bus.resp_valid, e_rv); end
      checks++; if (bus.wk_dout_ready !== e_dr) begin failures++; $display("FAIL rnd_dout_ready[%0d]: got %b want %b", cyc, bus.wk_dout_ready, e_dr); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err[%0d]: got %b want 0", cyc, err); end
      if (bus.wk_dout_valid && e_dr) begin
        checks++; if (bus.resp_rd !== exp_q[0]) begin failures++; $display("FAIL rnd_resp_rd[%0d]: got %h want %h", cyc, bus.resp_rd, exp_q[0]); end
        void'(tag_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (e_rr != '0) begin
        tag_q.push_back(g);
        exp_q.push_back(wk_fn(ins[g], r1[g], r2[g], r3[g]));
        next_ptr = (g + 1) % NREQ;
      end
      acc = bus.req_ready;
      if (bus.wk_din_valid && bus.wk_din_ready)
        wk_q.push_back(wk_fn(bus.wk_din_insn, bus.wk_din_rs1, bus.wk_din_rs2, bus.wk_din_rs3));
      if (bus.wk_dout_valid && bus.wk_dout_ready && wk_q.size() > 0)
        void'(wk_q.pop_front());
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_full();
    test_backpressure();
    test_protocol_error();
`ifdef RVB_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
